mem_responder: RTL and testbench

Word-addressed synchronous RAM that answers the datapath's memory requests. On `Read`, it returns `mem[MAR]` on `Mdatain`. On `Write`, it stores the MDR contents. Each completed access is signalled with a one-cycle `Ready` pulse after a configurable number of wait states. It sits between the datapath's MAR/MDR pair and the control sequencer, and replaces bench-driven `Mdatain` stimulus with a real responder.

---
 rtl/mem_responder.sv | 76 +++++++
 tb/tb_mem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering Read/Write requests with a Ready pulse after WAIT_STATES.
// Define MEM_BUSY_ERR_EN to enable the sticky Err flag for busy/colliding requests.
module mem_responder #(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              Read,
   input  logic              Write,
   input  logic [31:0]       MAR,
   input  logic [DATA_W-1:0] MDR,
   output logic [DATA_W-1:0] Mdatain,
   output logic              Ready,
   output logic              Busy,
   output logic              Err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_wr;
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic              w_req;
   logic              w_unused_mar;
   assign w_req        = Read | Write;
   assign w_unused_mar = ^MAR[31:ADDR_W];
   // Ready/Mdatain register the RESP cycle, so Busy stays high through the Ready cycle
   always_ff @(posedge clock or negedge clear)
      if (!clear) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wr    <= 1'b0;
         Mdatain <= '0;
         Ready   <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         Ready <= r_state == RESP;
         case (r_state)
            IDLE: begin
               Busy <= w_req;
               if (w_req) begin
                  r_addr  <= MAR[ADDR_W-1:0];
                  r_data  <= MDR;
                  r_wr    <= Write;
                  r_cnt   <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
                  r_state <= WAIT_STATES > 0 ? WAIT : RESP;
               end
            end
            WAIT:
               if (r_cnt == 4'd0) r_state <= RESP;
               else r_cnt <= r_cnt - 4'd1;
            RESP: begin
               if (!r_wr) Mdatain <= r_mem[r_addr];
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   // RAM has no reset; reset forces IDLE so an in-flight write never lands
   always_ff @(posedge clock)
      if (r_state == RESP && r_wr) r_mem[r_addr] <= r_data;
`ifdef MEM_BUSY_ERR_EN
   logic r_err;
   always_ff @(posedge clock or negedge clear)
      if (!clear) r_err <= 1'b0;
      else if ((w_req && r_state != IDLE) || (Read && Write && r_state == IDLE)) r_err <= 1'b1;
   assign Err = r_err;
`else
   assign Err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder with WAIT_STATES=2 and WAIT_STATES=0 instances.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        rd = 1'b0, wr = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0] mar = '0, mdr = '0, mar0 = '0, mdr0 = '0;
   logic [31:0] dout, dout0;
   logic        rdy, bsy, err, rdy0, bsy0, err0;
   int          checks = 0;
   int          errors = 0;
`ifdef MEM_BUSY_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   always #5 clk = ~clk;
   mem_responder #(.WAIT_STATES(2), .ADDR_W(9), .DATA_W(32)) u_ws2 (
      .clock(clk), .clear(clr_n), .Read(rd), .Write(wr), .MAR(mar), .MDR(mdr),
      .Mdatain(dout), .Ready(rdy), .Busy(bsy), .Err(err));
   mem_responder #(.WAIT_STATES(0), .ADDR_W(9), .DATA_W(32)) u_ws0 (
      .clock(clk), .clear(clr_n), .Read(rd0), .Write(wr0), .MAR(mar0), .MDR(mdr0),
      .Mdatain(dout0), .Ready(rdy0), .Busy(bsy0), .Err(err0));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // one-cycle request to the WAIT_STATES=2 instance; returns just after acceptance edge N
   task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rd = r; wr = w; mar = a; mdr = d;
      cyc(1);
      rd = 1'b0; wr = 1'b0;
   endtask
   initial begin
      cyc(2);
      chk("rst_busy", 32'(bsy), 0);
      chk("rst_ready", 32'(rdy), 0);
      chk("rst_mdatain", dout, 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_mdatain0", dout0, 0);
      clr_n = 1'b1;
      cyc(1);
      // write then read, WAIT_STATES=2
      req(0, 1, 32'h010, 32'hABCD1234);
      chk("wr_busy_n", 32'(bsy), 1);
      chk("wr_ready_n", 32'(rdy), 0);
      cyc(2);
      chk("wr_ready_n2", 32'(rdy), 0);
      chk("wr_busy_n2", 32'(bsy), 1);
      cyc(1);
      chk("wr_ready_n3", 32'(rdy), 1);
      chk("wr_busy_n3", 32'(bsy), 1);
      cyc(1);
      chk("wr_ready_n4", 32'(rdy), 0);
      chk("wr_busy_n4", 32'(bsy), 0);
      req(1, 0, 32'h010, 32'h0);
      cyc(3);
      chk("rd_ready", 32'(rdy), 1);
      chk("rd_data", dout, 32'hABCD1234);
      cyc(1);
      req(0, 1, 32'h011, 32'h00000008);
      cyc(3);
      chk("wr2_ready", 32'(rdy), 1);
      chk("wr2_mdatain_hold", dout, 32'hABCD1234);
      cyc(1);
      // reset mid-WAIT abandons pending write
      req(0, 1, 32'h020, 32'h11111111);
      cyc(4);
      req(0, 1, 32'h020, 32'hDEADBEEF);
      cyc(1);
      clr_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(bsy), 0);
      chk("mrst_ready", 32'(rdy), 0);
      chk("mrst_mdatain", dout, 0);
      clr_n = 1'b1;
      cyc(3);
      chk("mrst_no_ready", 32'(rdy), 0);
      req(1, 0, 32'h020, 32'h0);
      cyc(3);
      chk("mrst_prior", dout, 32'h11111111);
      cyc(1);
      // address alias
      req(0, 1, 32'h00000205, 32'hCD1234AB);
      cyc(4);
      req(1, 0, 32'h005, 32'h0);
      cyc(3);
      chk("alias_data", dout, 32'hCD1234AB);
      cyc(1);
      // read/write collision: write wins
      req(1, 1, 32'h003, 32'h55AA55AA);
      cyc(3);
      chk("coll_ready", 32'(rdy), 1);
      chk("coll_mdatain_hold", dout, 32'hCD1234AB);
      chk("coll_err", 32'(err), 32'(EXP_ERR));
      cyc(1);
      req(1, 0, 32'h003, 32'h0);
      cyc(3);
      chk("coll_written", dout, 32'h55AA55AA);
      cyc(1);
      clr_n = 1'b0;
      #1;
      chk("err_cleared", 32'(err), 0);
      clr_n = 1'b1;
      cyc(1);
      // request while busy is ignored
      req(1, 0, 32'h010, 32'h0);
      cyc(1);
      rd = 1'b1; mar = 32'h005;
      cyc(1);
      rd = 1'b0;
      cyc(1);
      chk("busy_ready", 32'(rdy), 1);
      chk("busy_addr_kept", dout, 32'hABCD1234);
      chk("busy_err", 32'(err), 32'(EXP_ERR));
      cyc(1);
      chk("busy_done", 32'(bsy), 0);
      cyc(2);
      chk("busy_no_2nd_ready", 32'(rdy), 0);
      // zero wait states
      wr0 = 1'b1; mar0 = 32'h007; mdr0 = 32'h0BADF00D;
      cyc(1);
      wr0 = 1'b0;
      chk("z_wr_busy", 32'(bsy0), 1);
      cyc(1);
      chk("z_wr_ready", 32'(rdy0), 1);
      cyc(1);
      chk("z_wr_idle", 32'(bsy0), 0);
      rd0 = 1'b1;
      cyc(1);
      cyc(1);
      chk("z_rd_ready", 32'(rdy0), 1);
      chk("z_rd_data", dout0, 32'h0BADF00D);
      cyc(1);
      rd0 = 1'b0;
      chk("z_rpt_ready_low", 32'(rdy0), 0);
      chk("z_rpt_busy", 32'(bsy0), 1);
      cyc(1);
      chk("z_rpt_ready", 32'(rdy0), 1);
      cyc(1);
      chk("z_rpt_idle", 32'(bsy0), 0);
      chk("z_err", 32'(err0), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
